// File: rtl/alu_accumulator.sv
// alu_accumulator: registered accumulator ALU, operand B fed back from ALUout[WIDTH-1:0].
// Define ALU_MULT_EN to build the multi-cycle shift-and-add multiplier for Function 4.
module alu_accumulator #(
    parameter int WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 start,
    input  logic [2:0]           Function,
    input  logic [WIDTH-1:0]     A,
    output logic [2*WIDTH-1:0]   ALUout,
    output logic                 busy,
    output logic                 done
);
    localparam int RW = 2 * WIDTH;

    logic [RW-1:0]    aluout_d, aluout_q, result;
    logic             done_d, done_q;
    logic [WIDTH-1:0] b;

    assign b      = aluout_q[WIDTH-1:0];
    assign ALUout = aluout_q;
    assign done   = done_q;

    // Function 4 yields the held value; only the multiplier build overrides it
    always_comb begin
        case (Function)
            3'd0:    result = RW'(A) + RW'(b);
            3'd1:    result = RW'(|(A | b));
            3'd2:    result = RW'(|(A & b));
            3'd3:    result = {A, b};
            3'd4:    result = aluout_q;
            3'd5:    result = (32'(A) >= RW) ? '0 : RW'(b) << A;
            3'd6:    result = RW'(b) >> A;
            default: result = '0;
        endcase
    end

`ifdef ALU_MULT_EN
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MULT} state_t;

    state_t           state_d, state_q;
    logic [CW-1:0]    count_d, count_q;
    logic [RW-1:0]    prod_d, prod_q, prod_next;
    logic [WIDTH-1:0] mcand_d, mcand_q, mplier_d, mplier_q, mplier_sh;
    logic             busy_d, busy_q;

    assign busy      = busy_q;
    assign mplier_sh = mplier_q >> count_q;
    assign prod_next = prod_q + (mplier_sh[0] ? RW'(mcand_q) << count_q : '0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        busy_d   = busy_q;
        aluout_d = aluout_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (start && Function == 3'd4) begin
                mcand_d  = A;
                mplier_d = b;
                prod_d   = '0;
                count_d  = '0;
                busy_d   = 1'b1;
                state_d  = MULT;
            end else if (start) begin
                aluout_d = result;
                done_d   = 1'b1;
            end
        end else begin
            prod_d  = prod_next;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
                aluout_d = prod_next;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            count_q  <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            busy_q   <= 1'b0;
            aluout_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            busy_q   <= busy_d;
            aluout_q <= aluout_d;
            done_q   <= done_d;
        end
    end
`else
    assign busy = 1'b0;

    always_comb begin
        aluout_d = start ? result : aluout_q;
        done_d   = start;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            aluout_q <= '0;
            done_q   <= 1'b0;
        end else begin
            aluout_q <= aluout_d;
            done_q   <= done_d;
        end
    end
`endif
endmodule

// File: tb/tb_alu_accumulator.sv
// tb_alu_accumulator: vector table plus multiply/reset sequences, scoreboard fed on start, drained on done.
module tb_alu_accumulator;
    logic       Clock = 1'b0;
    logic       Resetn = 1'b1;
    logic       start = 1'b0;
    logic [2:0] Function = 3'd0;
    logic [3:0] A = 4'd0;
    logic [7:0] ALUout;
    logic       busy, done;
    int         tests = 0, fails = 0;
    logic [7:0] sb[$];

    typedef struct {logic [2:0] f; logic [3:0] a; logic [7:0] exp;} vec_t;
    vec_t vecs[19];

    alu_accumulator #(.WIDTH(4)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .Function(Function),
        .A(A), .ALUout(ALUout), .busy(busy), .done(done)
    );

    always #5 Clock = ~Clock;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endfunction

    always @(negedge Clock) begin
        if (Resetn && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done_unexpected: got done=1 with ALUout=0x%0h expected no completion", ALUout);
            end else begin
                chk("scoreboard_aluout", 32'(ALUout), 32'(sb.pop_front()));
            end
        end
    end

    task automatic op(input logic [2:0] f, input logic [3:0] a, input logic [7:0] exp);
        @(negedge Clock);
        start = 1'b1; Function = f; A = a;
        sb.push_back(exp);
        @(negedge Clock);
        start = 1'b0;
        chk("op_done", 32'(done), 32'd1);
        chk("op_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs = '{
            '{3'd0, 4'hF, 8'h0F}, '{3'd0, 4'h1, 8'h10}, '{3'd7, 4'h0, 8'h00},
            '{3'd0, 4'h5, 8'h05}, '{3'd3, 4'hA, 8'hA5}, '{3'd2, 4'hA, 8'h00},
            '{3'd1, 4'h0, 8'h00}, '{3'd0, 4'h9, 8'h09}, '{3'd5, 4'h3, 8'h48},
            '{3'd6, 4'h2, 8'h02}, '{3'd5, 4'h8, 8'h00}, '{3'd0, 4'h3, 8'h03},
            '{3'd1, 4'h0, 8'h01}, '{3'd2, 4'h1, 8'h01}, '{3'd5, 4'h7, 8'h80},
            '{3'd6, 4'h0, 8'h00}, '{3'd0, 4'hF, 8'h0F}, '{3'd0, 4'hF, 8'h1E},
            '{3'd6, 4'h1, 8'h07}
        };
        #2 Resetn = 1'b0;
        #1;
        chk("reset_aluout", 32'(ALUout), 32'h00);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        // back-to-back starts, each using the B written by the previous one
        foreach (vecs[i]) begin
            @(negedge Clock);
            start = 1'b1; Function = vecs[i].f; A = vecs[i].a;
            sb.push_back(vecs[i].exp);
        end
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        chk("table_drained", 32'(sb.size()), 32'd0);
        chk("idle_done_low", 32'(done), 32'd0);

        op(3'd7, 4'h0, 8'h00);
        op(3'd0, 4'hB, 8'h0B);
`ifdef ALU_MULT_EN
        @(negedge Clock);
        start = 1'b1; Function = 3'd4; A = 4'hD;
        sb.push_back(8'h8F);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            Function = 3'd0; A = 4'h1;
            chk("mult_busy", 32'(busy), 32'd1);
            chk("mult_hold", 32'(ALUout), 32'h0B);
            chk("mult_no_done", 32'(done), 32'd0);
        end
        @(negedge Clock);
        start = 1'b0;
        chk("mult_busy_fall", 32'(busy), 32'd0);
        chk("mult_done", 32'(done), 32'd1);
        @(negedge Clock);
        chk("mult_done_once", 32'(done), 32'd0);
        chk("mult_result_held", 32'(ALUout), 32'h8F);
        chk("mult_busy_stays_low", 32'(busy), 32'd0);

        op(3'd7, 4'h0, 8'h00);
        op(3'd0, 4'h5, 8'h05);
        @(negedge Clock);
        start = 1'b1; Function = 3'd4; A = 4'h3;
        @(negedge Clock);
        start = 1'b0;
        @(posedge Clock);
        #2 Resetn = 1'b0;
        #1;
        chk("abort_aluout", 32'(ALUout), 32'h00);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        op(3'd0, 4'h3, 8'h03);
`else
        op(3'd4, 4'hD, 8'h0B);
        @(negedge Clock);
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_aluout", 32'(ALUout), 32'h0B);
        chk("hold_done_once", 32'(done), 32'd0);
        op(3'd0, 4'h3, 8'h0E);
`endif
        @(negedge Clock);
        @(negedge Clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
